// File: rtl/hci_bank_arbiter_n.sv
// Per-bank N-class arbiter in front of a banked memory: fixed priority with a
// starvation override or round-robin, plus one-cycle read response routing.
module hci_bank_arbiter_n #(
    parameter int N_IN   = 3,
    parameter int N_BANK = 16,
    parameter int DW     = 32,
    parameter int AW     = 16,
    parameter int CNT_W  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          mode_i,
    input  logic [CNT_W-1:0]              max_stall_i,
    input  logic [N_IN*N_BANK-1:0]        in_req_i,
    input  logic [N_IN*N_BANK-1:0]        in_wen_i,
    input  logic [N_IN*N_BANK*AW-1:0]     in_add_i,
    input  logic [N_IN*N_BANK*DW-1:0]     in_data_i,
    input  logic [N_IN*N_BANK*DW/8-1:0]   in_be_i,
    output logic [N_IN*N_BANK-1:0]        in_gnt_o,
    output logic [N_IN*N_BANK-1:0]        in_r_valid_o,
    output logic [N_IN*N_BANK*DW-1:0]     in_r_data_o,
    output logic [N_BANK-1:0]             mem_req_o,
    output logic [N_BANK-1:0]             mem_wen_o,
    output logic [N_BANK*AW-1:0]          mem_add_o,
    output logic [N_BANK*DW-1:0]          mem_data_o,
    output logic [N_BANK*DW/8-1:0]        mem_be_o,
    input  logic [N_BANK-1:0]             mem_gnt_i,
    input  logic [N_BANK*DW-1:0]          mem_r_data_i,
    output logic [N_BANK-1:0]             starve_evt_o
);

    localparam int NT = N_IN * N_BANK;
    localparam int BW = DW / 8;
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [NT*CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [N_BANK*IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_BANK-1:0]    pend_q, pend_d;
    logic [N_BANK*IW-1:0] pend_win_q, pend_win_d;
    logic [N_BANK-1:0]    starve_evt_q, starve_evt_d;

    logic                 req_any, any_st, g, ovr, rd, req_c, starved_c;
    logic [IW-1:0]        plain_w, starve_w, rr_w, w;
    logic [CNT_W-1:0]     cnt;
    int                   p, d, best_d;

    always_comb begin
        in_gnt_o     = '0;
        mem_req_o    = '0;
        mem_wen_o    = '0;
        mem_add_o    = '0;
        mem_data_o   = '0;
        mem_be_o     = '0;
        stall_cnt_d  = stall_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        pend_d       = '0;
        pend_win_d   = pend_win_q;
        starve_evt_d = '0;
        req_any      = 1'b0;
        any_st       = 1'b0;
        g            = 1'b0;
        ovr          = 1'b0;
        rd           = 1'b0;
        req_c        = 1'b0;
        starved_c    = 1'b0;
        plain_w      = '0;
        starve_w     = '0;
        rr_w         = '0;
        w            = '0;
        cnt          = '0;
        p            = 0;
        d            = 0;
        best_d       = 0;

        for (int b = 0; b < N_BANK; b++) begin
            req_any  = 1'b0;
            any_st   = 1'b0;
            plain_w  = '0;
            starve_w = '0;
            rr_w     = '0;
            best_d   = N_IN;
            p        = int'(rr_ptr_q[b*IW +: IW]);

            // Descending scan so the lowest-index candidate is the one left standing.
            for (int c = N_IN - 1; c >= 0; c--) begin
                req_c     = in_req_i[c*N_BANK+b];
                cnt       = stall_cnt_q[(c*N_BANK+b)*CNT_W +: CNT_W];
                starved_c = req_c && (N_IN > 1) && (max_stall_i != '0) && (cnt >= max_stall_i);
                if (req_c) begin
                    req_any = 1'b1;
                    plain_w = IW'(c);
                end
                if (starved_c) begin
                    any_st   = 1'b1;
                    starve_w = IW'(c);
                end
            end

            for (int c = 0; c < N_IN; c++) begin
                d = (c - p + N_IN) % N_IN;
                if (in_req_i[c*N_BANK+b] && d < best_d) begin
                    best_d = d;
                    rr_w   = IW'(c);
                end
            end

            w   = mode_i ? rr_w : (any_st ? starve_w : plain_w);
            ovr = !mode_i && any_st && (starve_w != plain_w);
            g   = req_any && mem_gnt_i[b];
            rd  = 1'b0;

            mem_req_o[b] = req_any;
            for (int c = 0; c < N_IN; c++) begin
                if (w == IW'(c)) begin
                    mem_wen_o[b]               = in_wen_i[c*N_BANK+b];
                    mem_add_o[b*AW +: AW]      = in_add_i[(c*N_BANK+b)*AW +: AW];
                    mem_data_o[b*DW +: DW]     = in_data_i[(c*N_BANK+b)*DW +: DW];
                    mem_be_o[b*BW +: BW]       = in_be_i[(c*N_BANK+b)*BW +: BW];
                    in_gnt_o[c*N_BANK+b]       = g;
                    rd                         = in_wen_i[c*N_BANK+b];
                end
            end

            for (int c = 0; c < N_IN; c++) begin
                cnt = stall_cnt_q[(c*N_BANK+b)*CNT_W +: CNT_W];
                if (in_req_i[c*N_BANK+b] && !(g && w == IW'(c))) begin
                    if (cnt != {CNT_W{1'b1}}) cnt = cnt + 1'b1;
                end else begin
                    cnt = '0;
                end
                stall_cnt_d[(c*N_BANK+b)*CNT_W +: CNT_W] = cnt;
            end

            if (g && mode_i) begin
                rr_ptr_d[b*IW +: IW] = (int'(w) == N_IN - 1) ? '0 : w + 1'b1;
            end

            pend_d[b]       = g && rd;
            if (g && rd) pend_win_d[b*IW +: IW] = w;
            starve_evt_d[b] = g && ovr;
        end

        if (clear_i) begin
            stall_cnt_d  = '0;
            rr_ptr_d     = '0;
            pend_d       = '0;
            pend_win_d   = '0;
            starve_evt_d = '0;
        end
    end

    always_comb begin
        in_r_valid_o = '0;
        in_r_data_o  = '0;
        for (int b = 0; b < N_BANK; b++) begin
            for (int c = 0; c < N_IN; c++) begin
                in_r_valid_o[c*N_BANK+b]             = pend_q[b] && (pend_win_q[b*IW +: IW] == IW'(c));
                in_r_data_o[(c*N_BANK+b)*DW +: DW]   = mem_r_data_i[b*DW +: DW];
            end
        end
    end

    assign starve_evt_o = starve_evt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            rr_ptr_q     <= '0;
            pend_q       <= '0;
            pend_win_q   <= '0;
            starve_evt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            pend_q       <= pend_d;
            pend_win_q   <= pend_win_d;
            starve_evt_q <= starve_evt_d;
        end
    end

endmodule

// File: tb/tb_hci_bank_arbiter_n.sv
// Directed bench for hci_bank_arbiter_n with hand-computed expectations.
module tb_hci_bank_arbiter_n;

    localparam int N_IN = 3, N_BANK = 16, DW = 32, AW = 16, CNT_W = 4;
    localparam int NT = N_IN * N_BANK;

    logic                  clk = 1'b0, rst = 1'b1, clear = 1'b0, mode = 1'b0;
    logic [CNT_W-1:0]      max_stall = '0;
    logic [NT-1:0]         req = '0, wen = '0;
    logic [NT*AW-1:0]      add = '0;
    logic [NT*DW-1:0]      data = '0;
    logic [NT*DW/8-1:0]    be = '0;
    logic [NT-1:0]         in_gnt, in_r_valid;
    logic [NT*DW-1:0]      in_r_data;
    logic [N_BANK-1:0]     mem_req, mem_wen, mem_gnt = '1, starve_evt;
    logic [N_BANK*AW-1:0]  mem_add;
    logic [N_BANK*DW-1:0]  mem_data, mem_rdata = '0;
    logic [N_BANK*DW/8-1:0] mem_be;

    int passed = 0, failed = 0, total = 0;

    hci_bank_arbiter_n #(.N_IN(N_IN), .N_BANK(N_BANK), .DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode), .max_stall_i(max_stall),
        .in_req_i(req), .in_wen_i(wen), .in_add_i(add), .in_data_i(data), .in_be_i(be),
        .in_gnt_o(in_gnt), .in_r_valid_o(in_r_valid), .in_r_data_o(in_r_data),
        .mem_req_o(mem_req), .mem_wen_o(mem_wen), .mem_add_o(mem_add), .mem_data_o(mem_data),
        .mem_be_o(mem_be), .mem_gnt_i(mem_gnt), .mem_r_data_i(mem_rdata), .starve_evt_o(starve_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input int c, input int b);
        return c * N_BANK + b;
    endfunction

    function automatic logic [NT-1:0] bit1(input int i);
        logic [NT-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [NT-1:0]        acc, exp_gnt;
    logic [N_BANK*DW-1:0] exp_data;
    int                   ew, c2;

    initial begin
        // Reset state
        tick; tick;
        chk("rst_rvalid", in_r_valid, '0);
        chk("rst_evt", starve_evt, '0);
        chk("rst_memreq", mem_req, '0);
        chk("rst_gnt", in_gnt, '0);
        rst = 1'b0;

        // Fixed priority with starvation override on bank 3
        mode = 1'b0; max_stall = 4'd4;
        req[idx(0,3)] = 1'b1; req[idx(2,3)] = 1'b1;
        add[idx(0,3)*AW +: AW] = 16'h1111; add[idx(2,3)*AW +: AW] = 16'h2222;
        for (int i = 1; i <= 6; i++) begin
            #1;
            ew = (i == 5) ? 2 : 0;
            chk($sformatf("starve_gnt_c%0d", i), in_gnt, bit1(idx(ew,3)));
            chk($sformatf("starve_add_c%0d", i), mem_add[3*AW +: AW], (i == 5) ? 16'h2222 : 16'h1111);
            chk($sformatf("starve_evt_c%0d", i), starve_evt, (i == 6) ? 16'h0008 : 16'h0000);
            tick;
        end
        req = '0; add = '0;
        tick;

        // Round-robin on bank 0
        mode = 1'b1;
        req[idx(0,0)] = 1'b1; req[idx(1,0)] = 1'b1; req[idx(2,0)] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr_gnt_%0d", i), in_gnt, bit1(idx(i % 3, 0)));
            tick;
        end
        mem_gnt[0] = 1'b0;
        #1 chk("rr_nognt", in_gnt, '0);
        tick;
        mem_gnt[0] = 1'b1;
        #1 chk("rr_ptr_held", in_gnt, bit1(idx(2,0)));
        tick;
        req = '0;
        tick;

        // Read response routing on bank 5
        mode = 1'b0;
        req[idx(1,5)] = 1'b1; wen[idx(1,5)] = 1'b1;
        #1 chk("rd_gnt", in_gnt, bit1(idx(1,5)));
        chk("rd_wen", mem_wen[5], 1'b1);
        tick;
        req = '0; wen = '0;
        mem_rdata[5*DW +: DW] = 32'hDEADBEEF;
        req[idx(0,5)] = 1'b1;
        #1 chk("rd_rvalid", in_r_valid, bit1(idx(1,5)));
        chk("rd_rdata", in_r_data[idx(1,5)*DW +: DW], 32'hDEADBEEF);
        chk("rd_bcast", in_r_data[idx(2,5)*DW +: DW], 32'hDEADBEEF);
        tick;
        req = '0; mem_rdata = '0;
        #1 chk("wr_no_rvalid", in_r_valid, '0);
        tick;

        // Stall saturation on bank 7
        max_stall = 4'd15; mem_gnt[7] = 1'b0; req[idx(1,7)] = 1'b1;
        acc = '0;
        repeat (20) begin
            #1 acc = acc | in_gnt;
            tick;
        end
        chk("sat_nognt", acc, '0);
        mem_gnt[7] = 1'b1; req[idx(0,7)] = 1'b1;
        #1 chk("sat_override", in_gnt, bit1(idx(1,7)));
        tick;
        req[idx(1,7)] = 1'b0;
        #1 chk("sat_evt", starve_evt, 16'h0080);
        chk("sat_next", in_gnt, bit1(idx(0,7)));
        tick;
        #1 chk("sat_evt_gone", starve_evt, '0);
        req = '0;
        tick;

        // Reset mid-read, with class 1 stalled on bank 2 across the reset
        max_stall = 4'd2; mem_gnt[2] = 1'b0; req[idx(1,2)] = 1'b1;
        tick; tick;
        req[idx(0,9)] = 1'b1; wen[idx(0,9)] = 1'b1;
        #1 chk("rst_rd_gnt", in_gnt, bit1(idx(0,9)));
        tick;
        req[idx(0,9)] = 1'b0; wen = '0;
        #1 chk("rst_rd_rvalid", in_r_valid, bit1(idx(0,9)));
        rst = 1'b1;
        #1 chk("rst_async_rvalid", in_r_valid, '0);
        req[idx(2,4)] = 1'b1;
        #1 chk("rst_comb_memreq", mem_req, 16'h0014);
        chk("rst_comb_gnt", in_gnt, bit1(idx(2,4)));
        tick; tick;
        req[idx(2,4)] = 1'b0; rst = 1'b0;
        req[idx(0,2)] = 1'b1; mem_gnt[2] = 1'b1;
        #1 chk("rst_c0_first", in_gnt, bit1(idx(0,2)));
        tick;
        req = '0;
        tick;

        // Synchronous clear: suppresses a read granted in the clear cycle and zeroes counters
        req[idx(2,1)] = 1'b1; wen[idx(2,1)] = 1'b1; clear = 1'b1;
        #1 chk("clr_gnt", in_gnt, bit1(idx(2,1)));
        tick;
        clear = 1'b0; req = '0; wen = '0;
        #1 chk("clr_no_rvalid", in_r_valid, '0);
        mem_gnt[6] = 1'b0; req[idx(2,6)] = 1'b1;
        tick; tick; tick;
        clear = 1'b1;
        tick;
        clear = 1'b0; mem_gnt[6] = 1'b1; req[idx(0,6)] = 1'b1;
        #1 chk("clr_cnt_zero", in_gnt, bit1(idx(0,6)));
        tick;
        req = '0;
        tick;

        // All 16 banks at once, independent winners
        max_stall = '0; exp_gnt = '0; exp_data = '0;
        for (int b = 0; b < N_BANK; b++) begin
            req[idx(b % 3, b)] = 1'b1;
            data[idx(b % 3, b)*DW +: DW] = 32'((b << 8) | (b % 3));
            ew = b % 3;
            if (b % 2 == 0) begin
                c2 = (b + 1) % 3;
                req[idx(c2, b)] = 1'b1;
                data[idx(c2, b)*DW +: DW] = 32'(32'hA000_0000 | (b << 8) | c2);
                if (c2 < ew) ew = c2;
            end
            exp_gnt[idx(ew, b)] = 1'b1;
            exp_data[b*DW +: DW] = data[idx(ew, b)*DW +: DW];
        end
        #1 chk("all_gnt", in_gnt, exp_gnt);
        chk("all_memreq", mem_req, 16'hFFFF);
        chk("all_data", mem_data, exp_data);
        tick;
        req = '0;
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
